// File: rtl/reward_update.sv
// Q-routing reward/update sequencer: fetches cluster cost, best-hop Q and action Q,
// then writes back A + ((sat(C+H) - A) >>> ALPHA_SHIFT) to the action entry.
module reward_update #(
    parameter int          WORD_WIDTH    = 16,
    parameter int          ADDR_WIDTH    = 16,
    parameter int          MEM_LATENCY   = 1,
    parameter int          ENTRY_BYTES   = 2,
    parameter int unsigned CLUSTER_BASE  = 'h148,
    parameter int unsigned HOP_BASE      = 'h1C8,
    parameter int unsigned ACTION_BASE   = 'h48,
    parameter int unsigned NUM_CLUSTERS  = 64,
    parameter int unsigned NUM_NEIGHBORS = 64,
    parameter int          ALPHA_SHIFT   = 1
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cluster_id,
    input  logic [WORD_WIDTH-1:0] action,
    input  logic [WORD_WIDTH-1:0] besthop,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic [WORD_WIDTH-1:0] q_new,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int CW = WORD_WIDTH + 32;

    typedef enum logic [3:0] {
        S_IDLE, S_ARM, S_RD_C, S_WT_C, S_RD_H, S_WT_H, S_RD_A, S_WT_A, S_CALC, S_WR, S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [WORD_WIDTH-1:0] r_cid, r_act, r_bh;
    logic [WORD_WIDTH-1:0] r_c, r_h, r_a, r_q;
    logic                  r_err;
    logic [2:0]            r_wcnt;

    logic                  w_launch, w_oob, w_wlast;
    logic [ADDR_WIDTH-1:0] w_addr_c, w_addr_h, w_addr_a;
    logic [WORD_WIDTH:0]   w_sum;
    logic [WORD_WIDTH-1:0] w_t, w_qc;
    logic signed [WORD_WIDTH:0]   w_d, w_sh;
    logic signed [WORD_WIDTH+1:0] w_r;

    assign w_launch = (r_state == S_ARM) && en && start;
    assign w_oob    = (CW'(cluster_id) >= CW'(NUM_CLUSTERS)) ||
                      (CW'(action)     >= CW'(NUM_NEIGHBORS)) ||
                      (CW'(besthop)    >= CW'(NUM_NEIGHBORS));
    assign w_wlast  = (r_wcnt == 3'd0);

    assign w_addr_c = ADDR_WIDTH'(CLUSTER_BASE) + ADDR_WIDTH'(r_cid) * ADDR_WIDTH'(ENTRY_BYTES);
    assign w_addr_h = ADDR_WIDTH'(HOP_BASE)     + ADDR_WIDTH'(r_bh)  * ADDR_WIDTH'(ENTRY_BYTES);
    assign w_addr_a = ADDR_WIDTH'(ACTION_BASE)  + ADDR_WIDTH'(r_act) * ADDR_WIDTH'(ENTRY_BYTES);

    // Saturating target, signed error, arithmetic shift, clamp back to unsigned range
    assign w_sum = {1'b0, r_c} + {1'b0, r_h};
    assign w_t   = w_sum[WORD_WIDTH] ? '1 : w_sum[WORD_WIDTH-1:0];
    assign w_d   = $signed({1'b0, w_t}) - $signed({1'b0, r_a});
    assign w_sh  = w_d >>> ALPHA_SHIFT;
    assign w_r   = $signed({2'b00, r_a}) + $signed({w_sh[WORD_WIDTH], w_sh});
    assign w_qc  = w_r[WORD_WIDTH+1] ? '0 : (w_r[WORD_WIDTH] ? '1 : w_r[WORD_WIDTH-1:0]);

    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_cid   <= '0;
            r_act   <= '0;
            r_bh    <= '0;
            r_c     <= '0;
            r_h     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_err   <= 1'b0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_cid <= cluster_id;
                r_act <= action;
                r_bh  <= besthop;
                r_err <= w_oob;
            end
            case (r_state)
                S_RD_C, S_RD_H, S_RD_A: r_wcnt <= 3'(MEM_LATENCY - 1);
                S_WT_C, S_WT_H, S_WT_A: if (!w_wlast) r_wcnt <= r_wcnt - 3'd1;
                default: ;
            endcase
            if (w_wlast) begin
                if (r_state == S_WT_C) r_c <= mem_rdata;
                if (r_state == S_WT_H) r_h <= mem_rdata;
                if (r_state == S_WT_A) r_a <= mem_rdata;
            end
            if (r_state == S_CALC) r_q <= w_qc;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (en) w_next = S_ARM;
            S_ARM:  if (!en) w_next = S_IDLE;
                    else if (start) w_next = w_oob ? S_DONE : S_RD_C;
            S_RD_C: w_next = S_WT_C;
            S_WT_C: if (w_wlast) w_next = S_RD_H;
            S_RD_H: w_next = S_WT_H;
            S_WT_H: if (w_wlast) w_next = S_RD_A;
            S_RD_A: w_next = S_WT_A;
            S_WT_A: if (w_wlast) w_next = S_CALC;
            S_CALC: w_next = S_WR;
            S_WR:   w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = !((r_state == S_IDLE) || (r_state == S_ARM));
        done      = (r_state == S_DONE);
        case (r_state)
            S_RD_C: begin mem_addr = w_addr_c; mem_re = 1'b1; end
            S_WT_C: mem_addr = w_addr_c;
            S_RD_H: begin mem_addr = w_addr_h; mem_re = 1'b1; end
            S_WT_H: mem_addr = w_addr_h;
            S_RD_A: begin mem_addr = w_addr_a; mem_re = 1'b1; end
            S_WT_A: mem_addr = w_addr_a;
            S_WR:   begin mem_addr = w_addr_a; mem_we = 1'b1; mem_wdata = r_q; end
            default: ;
        endcase
    end

    assign q_new = r_q;
    assign err   = r_err;
endmodule

// File: tb/tb_reward_update.sv
// Bench for reward_update: three instances (lat1/shift1, lat3/shift1, lat1/shift0)
// run the same directed launches against a cycle-accurate model of the update.
module tb_reward_update;
    localparam int NI = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        nrst, en, start;
    logic [15:0] cid, act, bh;
    logic [15:0] rdata [NI];
    logic [15:0] addr  [NI];
    logic [15:0] wdata [NI];
    logic [15:0] q     [NI];
    logic        re [NI], we [NI], busy [NI], done [NI], err [NI];
    logic [15:0] mem [0:1023];

    int errors = 0;
    int checks = 0;
    logic [15:0] lastq [NI];

    function automatic int lat(int g); return (g == 1) ? 3 : 1; endfunction
    function automatic int ash(int g); return (g == 2) ? 0 : 1; endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int L = (g == 1) ? 3 : 1;
        logic [15:0] pipe [4];
        always @(posedge clock) begin
            pipe[0] <= re[g] ? mem[addr[g][9:0]] : 16'hDEAD;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign rdata[g] = pipe[L-1];
        reward_update #(.MEM_LATENCY(L), .ALPHA_SHIFT((g == 2) ? 0 : 1)) dut (
            .clock(clock), .nrst(nrst), .en(en), .start(start),
            .cluster_id(cid), .action(act), .besthop(bh), .mem_rdata(rdata[g]),
            .mem_addr(addr[g]), .mem_re(re[g]), .mem_we(we[g]), .mem_wdata(wdata[g]),
            .q_new(q[g]), .busy(busy[g]), .done(done[g]), .err(err[g]));
    end

    // Spec-level Q update on plain integers
    function automatic logic [15:0] qm(int c, int h, int a, int s);
        int t, d, r;
        t = c + h;
        if (t > 65535) t = 65535;
        d = t - a;
        r = a + (d >>> s);
        if (r < 0) r = 0;
        if (r > 65535) r = 65535;
        return 16'(r);
    endfunction

    task automatic chk(string nm, int g, int k, logic [31:0] av, logic [31:0] ev);
        checks++;
        if (av !== ev) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d: got %h want %h", nm, g, k, av, ev);
        end
    endtask

    task automatic chk_reset(int g);
        chk("rst_addr", g, -1, 32'(addr[g]), 0);
        chk("rst_re", g, -1, 32'(re[g]), 0);
        chk("rst_we", g, -1, 32'(we[g]), 0);
        chk("rst_wdata", g, -1, 32'(wdata[g]), 0);
        chk("rst_q", g, -1, 32'(q[g]), 0);
        chk("rst_busy", g, -1, 32'(busy[g]), 0);
        chk("rst_done", g, -1, 32'(done[g]), 0);
        chk("rst_err", g, -1, 32'(err[g]), 0);
    endtask

    // Compare every instance against the model for cycle k after E0
    task automatic chk_cycle(int k, int c, int a, int b, bit oob, logic [15:0] expq [NI]);
        int n, l, ph, ea;
        for (int g = 0; g < NI; g++) begin
            l = lat(g);
            n = 3 * (1 + l);
            if (oob) begin
                chk("busy", g, k, 32'(busy[g]), 32'(k == 0));
                chk("done", g, k, 32'(done[g]), 32'(k == 0));
                chk("re", g, k, 32'(re[g]), 0);
                chk("we", g, k, 32'(we[g]), 0);
                chk("err", g, k, 32'(err[g]), 1);
                chk("q", g, k, 32'(q[g]), 32'(lastq[g]));
            end else begin
                chk("busy", g, k, 32'(busy[g]), 32'(k <= n + 2));
                chk("done", g, k, 32'(done[g]), 32'(k == n + 2));
                chk("re", g, k, 32'(re[g]), 32'(k < n && (k % (1 + l)) == 0));
                chk("we", g, k, 32'(we[g]), 32'(k == n + 1));
                chk("err", g, k, 32'(err[g]), 0);
                chk("q", g, k, 32'(q[g]), 32'((k <= n) ? lastq[g] : expq[g]));
                if (k < n) begin
                    ph = k / (1 + l);
                    ea = (ph == 0) ? 'h148 + 2 * c : (ph == 1) ? 'h1C8 + 2 * b : 'h48 + 2 * a;
                    chk("rd_addr", g, k, 32'(addr[g]), 32'(ea[15:0]));
                end
                if (k == n + 1) begin
                    chk("wr_addr", g, k, 32'(addr[g]), 32'(16'('h48 + 2 * a)));
                    chk("wr_data", g, k, 32'(wdata[g]), 32'(expq[g]));
                end
            end
        end
    endtask

    task automatic run(int c, int a, int b, int vc, int vh, int va,
                       logic [15:0] lit0, logic [15:0] lit2, int rst_at);
        logic [15:0] expq [NI];
        bit oob;
        oob = (c >= 64) || (a >= 64) || (b >= 64);
        if (!oob) begin
            mem[10'('h148 + 2 * c)] = 16'(vc);
            mem[10'('h1C8 + 2 * b)] = 16'(vh);
            mem[10'('h48 + 2 * a)]  = 16'(va);
        end
        for (int g = 0; g < NI; g++) expq[g] = oob ? lastq[g] : qm(vc, vh, va, ash(g));
        @(negedge clock);
        en = 1'b1; cid = 16'(c); act = 16'(a); bh = 16'(b);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0; en = 1'b0;
        cid = 16'h0007; act = 16'h0009; bh = 16'h000B;
        for (int k = 0; k < 18; k++) begin
            chk_cycle(k, c, a, b, oob, expq);
            if (k == rst_at) begin
                nrst = 1'b0;
                @(negedge clock);
                nrst = 1'b1;
                for (int g = 0; g < NI; g++) begin chk_reset(g); lastq[g] = 16'h0; end
                for (int j = 0; j < 16; j++) begin
                    @(negedge clock);
                    for (int g = 0; g < NI; g++) begin
                        chk("post_rst_re", g, j, 32'(re[g]), 0);
                        chk("post_rst_we", g, j, 32'(we[g]), 0);
                        chk("post_rst_busy", g, j, 32'(busy[g]), 0);
                    end
                end
                return;
            end
            @(negedge clock);
        end
        for (int g = 0; g < NI; g++) lastq[g] = expq[g];
        chk("q_lit", 0, 99, 32'(q[0]), 32'(lit0));
        chk("q_lit", 2, 99, 32'(q[2]), 32'(lit2));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        for (int g = 0; g < NI; g++) lastq[g] = 16'h0;
        nrst = 1'b0; en = 1'b0; start = 1'b0; cid = '0; act = '0; bh = '0;
        repeat (2) @(negedge clock);
        for (int g = 0; g < NI; g++) chk_reset(g);
        nrst = 1'b1;
        // start without en is ignored in IDLE
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int g = 0; g < NI; g++) chk("idle_start", g, 0, 32'(busy[g]), 0);

        run(2, 3, 5, 'h0010, 'h0020, 'h0010, 16'h0020, 16'h0030, -1);   // nominal
        run(10, 20, 30, 'hFFF0, 'h0100, 'h0000, 16'h7FFF, 16'hFFFF, -1); // saturation
        run(0, 63, 63, 'h0000, 'h0000, 'h0040, 16'h0020, 16'h0000, -1);  // decrease, index edges
        run(2, 64, 5, 0, 0, 0, 16'h0020, 16'h0000, -1);                  // action out of range
        run(1, 1, 16'hFFFF, 0, 0, 0, 16'h0020, 16'h0000, -1);            // besthop out of range
        run(2, 3, 5, 'h0010, 'h0020, 'h0010, 16'h0020, 16'h0030, 3);     // reset mid-read
        run(2, 3, 5, 'h0010, 'h0020, 'h0010, 16'h0020, 16'h0030, -1);   // recovers

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reward_update.md
# reward_update

Parametrised Q-routing reward/update sequencer for the sensor-node datapath, successor to the fixed-address reward block. On `start` it snapshots the routing indices and fetches three Q-table entries from node memory: cluster cost, best-hop Q, and current action Q. It then computes a learning-rate-scaled Q update, writes the new value back to the action entry, and signals completion with a one-cycle `done` pulse. It sits between the packet-decode controller and the shared node memory port, and supports configurable widths, table bases, memory read latency, index bounds and learning rate.

## Interface
Parameters:
- WORD_WIDTH, 16, data/index width
- ADDR_WIDTH, 16, memory address width
- MEM_LATENCY, 1, read latency in cycles (legal 1..4)
- ENTRY_BYTES, 2, address stride per table entry
- CLUSTER_BASE, 16'h148, cluster-cost table base
- HOP_BASE, 16'h1C8, neighbour Q table base
- ACTION_BASE, 16'h48, action Q table base
- NUM_CLUSTERS, 64, legal cluster_id range 0..NUM_CLUSTERS-1
- NUM_NEIGHBORS, 64, legal action/besthop range 0..NUM_NEIGHBORS-1
- ALPHA_SHIFT, 1, learning rate = 2^-ALPHA_SHIFT (legal 0..WORD_WIDTH-1)

Ports:
- clock  in  1  system clock, all logic on posedge
- nrst  in  1  synchronous active-low reset
- en  in  1  arms the block from IDLE
- start  in  1  launches an update when armed
- cluster_id, action, besthop  in  WORD_WIDTH  table indices, sampled on start acceptance
- mem_rdata  in  WORD_WIDTH  memory read data
- mem_addr  out  ADDR_WIDTH  memory address
- mem_re  out  1  read strobe, one cycle per read
- mem_we  out  1  write strobe, one cycle
- mem_wdata  out  WORD_WIDTH  write data (= q_new)
- q_new  out  WORD_WIDTH  last computed Q value
- busy  out  1  high in every state except IDLE/ARM
- done  out  1  one-cycle completion pulse
- err  out  1  index out of range on last launch

## Operation
- States: IDLE, ARM, RD_C, WT_C, RD_H, WT_H, RD_A, WT_A, CALC, WR, DONE.
- IDLE: go to ARM when en=1; otherwise stay. start is ignored.
- ARM: en=0 returns to IDLE. When start=1, latch cluster_id/action/besthop, clear err, and range-check the indices.
  - Any index out of range: set err=1, go to DONE. No memory access, q_new unchanged.
  - All in range: go to RD_C.
- RD_x: drive mem_addr = BASE_x + idx*ENTRY_BYTES (truncated to ADDR_WIDTH) with mem_re=1.
- WT_x: hold mem_addr for MEM_LATENCY cycles, mem_re=0. Capture mem_rdata on the edge ending the last WT cycle.
- Read order and captured values: cluster cost C (CLUSTER_BASE, cluster_id), hop Q H (HOP_BASE, besthop), action Q A (ACTION_BASE, action).
- CALC: compute and register q_new.
  - T = min(C+H, 2^WORD_WIDTH-1), unsigned saturating add.
  - D = T−A as a signed WORD_WIDTH+1 value.
  - q_new = clamp(A + (D >>> ALPHA_SHIFT), 0, 2^WORD_WIDTH-1), arithmetic shift.
- WR: mem_addr = action address, mem_wdata = q_new, mem_we=1 for one cycle.
- DONE: done=1 for one cycle, then IDLE. en must be re-asserted before the next launch.
- en and start are ignored outside IDLE/ARM. Indices are snapshots, so input changes mid-operation have no effect.

## Timing
- Reset values: state IDLE, mem_addr 0, mem_re 0, mem_we 0, mem_wdata 0, q_new 0, busy 0, done 0, err 0.
- mem_re and mem_we are never high in the same cycle. At most one strobe per cycle.
- Call E0 the edge that samples start in ARM. Normal path: reads occupy 3·(1+MEM_LATENCY) cycles, then CALC 1, WR 1, DONE 1.
  - done is high in cycle 3·(1+MEM_LATENCY)+2 after E0, i.e. cycle 8 for MEM_LATENCY=1.
- Error path: done is high in cycle 0 after E0.
- err is valid with done and holds until the next start acceptance. q_new holds until the next CALC.
- Reset mid-operation: the next cycle shows reset values. No further strobes, and no partial write is issued.

## Test plan
- Nominal, MEM_LATENCY=1, ALPHA_SHIFT=1. cluster_id=2, besthop=5, action=3; memory returns C=0x0010, H=0x0020, A=0x0010.
  - Reads issued at 0x14C, 0x1D2, 0x4E in that order.
  - Write at 0x4E with data 0x0020; q_new=0x0020, done pulses in cycle 8 after E0, err=0.
- Saturation: C=0xFFF0, H=0x0100, A=0x0000 → T=0xFFFF, q_new=0x7FFF written.
- Decrease: C=0, H=0, A=0x0040 → q_new=0x0020. With ALPHA_SHIFT=0, same stimulus → q_new=0x0000.
- Error: action=NUM_NEIGHBORS (64) → no mem_re/mem_we, err=1, done in cycle 0 after E0, q_new unchanged.
- Latency: MEM_LATENCY=3 with nominal stimulus → each mem_addr held 4 cycles, done in cycle 14 after E0, same q_new=0x0020.
- Reset in WT_H: nrst=0 for one cycle → all outputs at reset values, no write. A subsequent en/start completes normally.
